// File: rtl/wishbone_master_bridge.sv
// Core-side single-request load/store port to Wishbone classic master cycles.
// Handles grant arbitration, rty back-off/retry, per-attempt timeout and one response per request.
module wishbone_master_bridge #(
    parameter int TAGSIZE   = 1,
    parameter int MAX_RETRY = 4,
    parameter int RETRY_GAP = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [31:0]        req_adr_i,
    input  logic [31:0]        req_dat_i,
    input  logic [3:0]         req_sel_i,
    input  logic [TAGSIZE-1:0] req_tag_i,
    input  logic               req_lock_i,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_dat_o,
    output logic [TAGSIZE-1:0] rsp_tgd_o,
    output logic               rsp_err_o,
    output logic               rsp_timeout_o,
    output logic               cyc_o,
    output logic               stb_o,
    output logic               we_o,
    output logic [31:0]        adr_o,
    output logic [31:0]        dat_o,
    output logic [3:0]         sel_o,
    output logic [TAGSIZE-1:0] tga_o,
    output logic [TAGSIZE-1:0] tgd_o,
    output logic [TAGSIZE-1:0] tgc_o,
    output logic               lock_o,
    input  logic               gnt_i,
    input  logic               ack_i,
    input  logic               err_i,
    input  logic               rty_i,
    input  logic [31:0]        dat_i,
    input  logic [TAGSIZE-1:0] tgd_i
);

    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER,
        ST_BACKOFF,
        ST_RESP
    } state_t;

    state_t             state_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic [RTY_W-1:0]   retry_cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic               req_ready_reg;
    logic               cyc_reg;
    logic               stb_reg;
    logic               we_reg;
    logic [31:0]        adr_reg;
    logic [31:0]        dat_reg;
    logic [3:0]         sel_reg;
    logic [TAGSIZE-1:0] tag_reg;
    logic               lock_req_reg;
    logic               lock_reg;
    logic               rsp_valid_reg;
    logic [31:0]        rsp_dat_reg;
    logic [TAGSIZE-1:0] rsp_tgd_reg;
    logic               rsp_err_reg;
    logic               rsp_timeout_reg;

    logic [TMO_W-1:0]   tmo_inc;
    logic               tmo_hit;
    logic               retry_more;
    logic               gap_done;
    logic               fin;
    logic               fin_err;
    logic               fin_tmo;
    logic               retry_go;

    assign tmo_inc    = tmo_cnt_reg + TMO_W'(1);
    assign tmo_hit    = (TIMEOUT != 0) && (tmo_inc == TMO_W'(TIMEOUT));
    assign retry_more = (retry_cnt_reg != RTY_W'(MAX_RETRY));
    assign gap_done   = (RETRY_GAP <= 1) || (gap_cnt_reg == GAP_W'(RETRY_GAP - 1));

    // Termination decode: err > rty > ack, then grant loss, then timeout.
    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_tmo  = 1'b0;
        retry_go = 1'b0;
        if (state_reg == ST_ARB) begin
            if (tmo_hit) begin
                fin     = 1'b1;
                fin_err = 1'b1;
                fin_tmo = 1'b1;
            end
        end else if (state_reg == ST_XFER) begin
            if (err_i) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end else if (rty_i) begin
                if (retry_more) begin
                    retry_go = 1'b1;
                end else begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end else if (ack_i) begin
                fin = 1'b1;
            end else if (!gnt_i || tmo_hit) begin
                fin     = 1'b1;
                fin_err = 1'b1;
                fin_tmo = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg       <= ST_IDLE;
            tmo_cnt_reg     <= '0;
            retry_cnt_reg   <= '0;
            gap_cnt_reg     <= '0;
            req_ready_reg   <= 1'b0;
            cyc_reg         <= 1'b0;
            stb_reg         <= 1'b0;
            we_reg          <= 1'b0;
            adr_reg         <= '0;
            dat_reg         <= '0;
            sel_reg         <= '0;
            tag_reg         <= '0;
            lock_req_reg    <= 1'b0;
            lock_reg        <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_dat_reg     <= '0;
            rsp_tgd_reg     <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid_i && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        we_reg        <= req_we_i;
                        adr_reg       <= req_adr_i;
                        dat_reg       <= req_dat_i;
                        sel_reg       <= req_sel_i;
                        tag_reg       <= req_tag_i;
                        lock_req_reg  <= req_lock_i;
                        lock_reg      <= req_lock_i;
                        retry_cnt_reg <= '0;
                        tmo_cnt_reg   <= '0;
                        cyc_reg       <= 1'b1;
                        state_reg     <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    tmo_cnt_reg <= tmo_inc;
                    if (gnt_i) begin
                        stb_reg   <= 1'b1;
                        state_reg <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    tmo_cnt_reg <= tmo_inc;
                    if (retry_go) begin
                        retry_cnt_reg <= retry_cnt_reg + RTY_W'(1);
                        tmo_cnt_reg   <= '0;
                        gap_cnt_reg   <= '0;
                        cyc_reg       <= 1'b0;
                        stb_reg       <= 1'b0;
                        lock_reg      <= 1'b0;
                        state_reg     <= ST_BACKOFF;
                    end
                end
                ST_BACKOFF: begin
                    if (gap_done) begin
                        cyc_reg   <= 1'b1;
                        lock_reg  <= lock_req_reg;
                        state_reg <= ST_ARB;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                ST_RESP: begin
                    req_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Any termination drops the cycle so the interconnect can re-arbitrate.
            if (fin) begin
                cyc_reg         <= 1'b0;
                stb_reg         <= 1'b0;
                lock_reg        <= 1'b0;
                rsp_valid_reg   <= 1'b1;
                rsp_err_reg     <= fin_err;
                rsp_timeout_reg <= fin_tmo;
                state_reg       <= ST_RESP;
                if (!fin_err) begin
                    rsp_dat_reg <= dat_i;
                    rsp_tgd_reg <= tgd_i;
                end
            end
        end
    end

    assign req_ready_o   = req_ready_reg;
    assign rsp_valid_o   = rsp_valid_reg;
    assign rsp_dat_o     = rsp_dat_reg;
    assign rsp_tgd_o     = rsp_tgd_reg;
    assign rsp_err_o     = rsp_err_reg;
    assign rsp_timeout_o = rsp_timeout_reg;
    assign cyc_o         = cyc_reg;
    assign stb_o         = stb_reg;
    assign we_o          = we_reg;
    assign adr_o         = adr_reg;
    assign dat_o         = dat_reg;
    assign sel_o         = sel_reg;
    assign tga_o         = tag_reg;
    assign tgd_o         = tag_reg;
    assign tgc_o         = tag_reg;
    assign lock_o        = lock_reg;

endmodule

// File: tb/tb_wishbone_master_bridge.sv
// Directed bench for wishbone_master_bridge: reads, writes, retries, errors, timeout and mid-cycle reset.
module tb_wishbone_master_bridge;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_adr_i = '0;
    logic [31:0] req_dat_i = '0;
    logic [3:0]  req_sel_i = '0;
    logic [0:0]  req_tag_i = '0;
    logic        req_lock_i = 1'b0;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic [0:0]  rsp_tgd_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [0:0]  tga_o, tgd_o, tgc_o;
    logic        lock_o;
    logic        gnt_i = 1'b0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        rty_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic [0:0]  tgd_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Per-access observations filled in by do_access
    int          r_rsp_n, r_rsp_t, r_first_stb, r_gaps, r_gap_min, r_gap_max, r_cyc_hi;
    logic        r_err, r_tmo, r_stb_early, r_we, r_lock_bad, r_cyc_at_rsp;
    logic [31:0] r_dat, r_adr, r_wdat;
    logic [3:0]  r_sel;

    wishbone_master_bridge #(
        .TAGSIZE  (1),
        .MAX_RETRY(4),
        .RETRY_GAP(2),
        .TIMEOUT  (8)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_adr_i    (req_adr_i),
        .req_dat_i    (req_dat_i),
        .req_sel_i    (req_sel_i),
        .req_tag_i    (req_tag_i),
        .req_lock_i   (req_lock_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_tgd_o    (rsp_tgd_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .sel_o        (sel_o),
        .tga_o        (tga_o),
        .tgd_o        (tgd_o),
        .tgc_o        (tgc_o),
        .lock_o       (lock_o),
        .gnt_i        (gnt_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .rty_i        (rty_i),
        .dat_i        (dat_i),
        .tgd_i        (tgd_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request; the slave grants after gnt_dly cycles of cyc_o, answers rty n_rty times,
    // then ends with term (0=ack, 1=err, 2=silent). Samples/drives on the falling edge.
    task automatic do_access(input string name, input logic we, input logic [31:0] adr,
                             input logic [31:0] wdat, input logic [3:0] sel, input logic lock,
                             input int gnt_dly, input int n_rty, input int term,
                             input logic [31:0] rdat);
        int   t, cyc_run, rty_left, low_run, post;
        logic prev_gnt, seen_cyc;
        r_rsp_n = 0; r_rsp_t = 0; r_first_stb = 0; r_gaps = 0; r_gap_min = 999; r_gap_max = 0;
        r_cyc_hi = 0; r_err = 1'bx; r_tmo = 1'bx; r_stb_early = 1'b0; r_we = 1'bx;
        r_lock_bad = 1'b0; r_cyc_at_rsp = 1'bx; r_dat = 'x; r_adr = 'x; r_wdat = 'x; r_sel = 'x;
        cyc_run = 0; rty_left = n_rty; low_run = 0; post = 0; prev_gnt = 1'b0; seen_cyc = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = wdat;
        req_sel_i = sel; req_lock_i = lock;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        t = 1;
        while (t <= 60 && post < 3) begin
            if (rsp_valid_o) begin
                if (r_rsp_n == 0) begin
                    r_rsp_t = t; r_err = rsp_err_o; r_tmo = rsp_timeout_o;
                    r_dat = rsp_dat_o; r_cyc_at_rsp = cyc_o;
                end
                r_rsp_n++;
            end
            if (r_rsp_n > 0) post++;
            if (cyc_o) begin
                if (r_rsp_n == 0) r_cyc_hi++;
                if (lock_o !== lock) r_lock_bad = 1'b1;
                if (seen_cyc && low_run > 0) begin
                    r_gaps++;
                    if (low_run < r_gap_min) r_gap_min = low_run;
                    if (low_run > r_gap_max) r_gap_max = low_run;
                end
                low_run = 0; seen_cyc = 1'b1; cyc_run++;
            end else begin
                if (lock_o) r_lock_bad = 1'b1;
                cyc_run = 0;
                if (seen_cyc && r_rsp_n == 0) low_run++;
            end
            if (stb_o && !prev_gnt) r_stb_early = 1'b1;
            if (stb_o && r_first_stb == 0) begin
                r_first_stb = t; r_we = we_o; r_sel = sel_o; r_adr = adr_o; r_wdat = dat_o;
            end
            gnt_i = cyc_o && (cyc_run > gnt_dly);
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
            if (stb_o) begin
                if (rty_left > 0) begin
                    rty_i = 1'b1; rty_left--;
                end else if (term == 0) begin
                    ack_i = 1'b1; dat_i = rdat;
                end else if (term == 1) begin
                    err_i = 1'b1;
                end
            end
            prev_gnt = gnt_i;
            @(negedge clk_i);
            t++;
        end
        gnt_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        $display("txn %s: rsp_n=%0d rsp_t=%0d err=%b tmo=%b dat=0x%08h gaps=%0d cyc_hi=%0d",
                 name, r_rsp_n, r_rsp_t, r_err, r_tmo, r_dat, r_gaps, r_cyc_hi);
    endtask

    initial begin
        int rsp_seen;
        // Reset state
        #12;
        check_val("rst_cyc", {31'd0, cyc_o}, 32'd0);
        check_val("rst_stb", {31'd0, stb_o}, 32'd0);
        check_val("rst_ready", {31'd0, req_ready_o}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check_val("rst_lock", {31'd0, lock_o}, 32'd0);
        check_val("rst_adr", adr_o, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_val("ready_after_rst", {31'd0, req_ready_o}, 32'd1);

        // Locked read, immediate grant and ack
        do_access("read_imm", 1'b0, 32'h100, 32'h0, 4'hF, 1'b1, 0, 0, 0, 32'hDEADBEEF);
        check_val("rd_rsp_n", r_rsp_n, 1);
        check_val("rd_latency", r_rsp_t, 3);
        check_val("rd_first_stb", r_first_stb, 2);
        check_val("rd_dat", r_dat, 32'hDEADBEEF);
        check_val("rd_err", {31'd0, r_err}, 32'd0);
        check_val("rd_we", {31'd0, r_we}, 32'd0);
        check_val("rd_adr", r_adr, 32'h100);
        check_val("rd_lock_bad", {31'd0, r_lock_bad}, 32'd0);

        // Write with grant delayed by 5 cycles
        do_access("write_gnt5", 1'b1, 32'h2004, 32'hA5A55A5A, 4'b0011, 1'b0, 5, 0, 0, 32'h0);
        check_val("wr_first_stb", r_first_stb, 7);
        check_val("wr_stb_early", {31'd0, r_stb_early}, 32'd0);
        check_val("wr_we", {31'd0, r_we}, 32'd1);
        check_val("wr_sel", {28'd0, r_sel}, 32'd3);
        check_val("wr_dat_o", r_wdat, 32'hA5A55A5A);
        check_val("wr_rsp_n", r_rsp_n, 1);
        check_val("wr_err", {31'd0, r_err}, 32'd0);
        check_val("wr_latency", r_rsp_t, 8);

        // Two rty then ack
        do_access("rty2_ack", 1'b0, 32'h300, 32'h0, 4'hF, 1'b0, 0, 2, 0, 32'hCAFEF00D);
        check_val("rty2_gaps", r_gaps, 2);
        check_val("rty2_gap_min", r_gap_min, 2);
        check_val("rty2_gap_max", r_gap_max, 2);
        check_val("rty2_err", {31'd0, r_err}, 32'd0);
        check_val("rty2_latency", r_rsp_t, 11);
        check_val("rty2_dat", r_dat, 32'hCAFEF00D);

        // Slave error
        do_access("err", 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, 0, 0, 1, 32'h11111111);
        check_val("err_err", {31'd0, r_err}, 32'd1);
        check_val("err_tmo", {31'd0, r_tmo}, 32'd0);
        check_val("err_latency", r_rsp_t, 3);
        check_val("err_dat_hold", r_dat, 32'hCAFEF00D);

        // Retries exhausted
        do_access("rty5", 1'b0, 32'h500, 32'h0, 4'hF, 1'b0, 0, 5, 0, 32'h22222222);
        check_val("rty5_err", {31'd0, r_err}, 32'd1);
        check_val("rty5_tmo", {31'd0, r_tmo}, 32'd0);
        check_val("rty5_gaps", r_gaps, 4);
        check_val("rty5_latency", r_rsp_t, 19);
        check_val("rty5_rsp_n", r_rsp_n, 1);

        // No termination: timeout after 8 cycles of cyc_o
        do_access("timeout", 1'b0, 32'h600, 32'h0, 4'hF, 1'b0, 0, 0, 2, 32'h0);
        check_val("tmo_err", {31'd0, r_err}, 32'd1);
        check_val("tmo_tmo", {31'd0, r_tmo}, 32'd1);
        check_val("tmo_latency", r_rsp_t, 9);
        check_val("tmo_cyc_hi", r_cyc_hi, 8);
        check_val("tmo_cyc_at_rsp", {31'd0, r_cyc_at_rsp}, 32'd0);
        check_val("tmo_dat_hold", r_dat, 32'hCAFEF00D);

        // Reset pulse while in XFER
        @(negedge clk_i);
        for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h700; req_lock_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0; gnt_i = 1'b1;
        @(negedge clk_i);
        check_val("mid_stb_before_rst", {31'd0, stb_o}, 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        check_val("mid_rst_cyc", {31'd0, cyc_o}, 32'd0);
        check_val("mid_rst_stb", {31'd0, stb_o}, 32'd0);
        check_val("mid_rst_lock", {31'd0, lock_o}, 32'd0);
        check_val("mid_rst_adr", adr_o, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1; gnt_i = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) rsp_seen++;
        end
        check_val("mid_rst_no_rsp", rsp_seen, 0);
        check_val("mid_rst_ready", {31'd0, req_ready_o}, 32'd1);
        $display("txn reset_mid_xfer: rsp_seen=%0d ready=%b", rsp_seen, req_ready_o);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
